// File: rtl/pkg_uart.sv
// pkg_uart: shared types and defaults for the UART receive datapath
package pkg_uart;
  typedef logic [3:0] count_t;
  localparam count_t LAST_COUNT = 4'd10;
  localparam int DEF_BAUD_DIV = 5208;
  localparam bit DEF_PARITY_ODD = 1'b0;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16-bit baud counter (clk, rst, enable, clear) emitting a one-cycle mid-bit tick
module uart_baud_tick
  import pkg_uart::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
  assign tick = enable & ~clear & (cnt == HALF);
endmodule

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: synchronizes i_rx, samples start/data/parity bits on baud ticks, latches o_data (i_load) and o_parity_err (i_pbit)
module uart_rx_datapath
  import pkg_uart::*;
#(
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter bit PARITY_ODD = DEF_PARITY_ODD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  input  logic       i_bauden,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic       i_pbit,
  output count_t     o_count,
  output logic [7:0] o_data,
  output logic       o_parity_err,
  output logic       o_start_err
);
  logic [1:0] sync;
  logic [7:0] shreg;
  logic rx_s, tick, pbit_r;
  assign rx_s = sync[1];
  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .enable(i_bauden),
    .clear(i_clear),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], i_rx};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_count <= '0;
      shreg <= '0;
      pbit_r <= 1'b0;
      o_start_err <= 1'b0;
      o_data <= 8'h00;
      o_parity_err <= 1'b0;
    end else begin
      if (i_clear) begin
        o_count <= '0;
        shreg <= '0;
        pbit_r <= 1'b0;
        o_start_err <= 1'b0;
      end else if (tick && o_count != LAST_COUNT) begin
        o_count <= o_count + 4'd1;
        if (o_count == 4'd0) o_start_err <= rx_s;
        else if (o_count != 4'd9) shreg <= {rx_s, shreg[7:1]};
        else pbit_r <= rx_s;
      end
      if (i_load) o_data <= shreg;
      if (i_pbit) o_parity_err <= ^(i_load ? shreg : o_data) ^ pbit_r ^ PARITY_ODD;
    end
endmodule

// File: tb/tb_uart_rx_datapath.sv
// tb_uart_rx_datapath: table-driven frames with a scoreboard plus hand-written corner sequences, even and odd parity instances
module tb_uart_rx_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_rx = 1'b1;
  logic i_bauden = 1'b0;
  logic i_clear = 1'b0;
  logic i_load = 1'b0;
  logic i_pbit = 1'b0;
  logic [3:0] o_count, o_count_o;
  logic [7:0] o_data, o_data_o;
  logic o_parity_err, o_parity_err_o, o_start_err, o_start_err_o;
  int checks = 0;
  int errors = 0;

  uart_rx_datapath #(.BAUD_DIV(16), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx), .i_bauden(i_bauden), .i_clear(i_clear),
    .i_load(i_load), .i_pbit(i_pbit), .o_count(o_count), .o_data(o_data),
    .o_parity_err(o_parity_err), .o_start_err(o_start_err)
  );
  uart_rx_datapath #(.BAUD_DIV(16), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .i_rx(i_rx), .i_bauden(i_bauden), .i_clear(i_clear),
    .i_load(i_load), .i_pbit(i_pbit), .o_count(o_count_o), .o_data(o_data_o),
    .o_parity_err(o_parity_err_o), .o_start_err(o_start_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    int         pause_at;
    int         pause_len;
    logic       together;
    logic       perr_even;
    logic       perr_odd;
  } vec_t;
  typedef struct {
    logic [7:0] data;
    logic       perr_even;
    logic       perr_odd;
  } exp_t;
  vec_t vecs[5];
  exp_t sb[$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int e);
    int c;
    c = (e < 8) ? 0 : (e - 8) / 16 + 1;
    return (c > 10) ? 10 : c;
  endfunction

  task automatic pulse_clear;
    i_clear = 1'b1;
    step;
    i_clear = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d, input logic p, input int n_edges,
                      input int pause_at, input int pause_len);
    logic [10:0] bits;
    int e;
    int pz;
    bits = {1'b1, p, d, 1'b0};
    e = 0;
    pz = 0;
    while (e < n_edges) begin
      i_rx = bits[e / 16];
      if (e == pause_at && pz < pause_len) begin
        i_bauden = 1'b0;
        pz++;
        step;
        chk("pause_count", 8'(o_count), 8'(exp_cnt(e)));
      end else begin
        i_bauden = 1'b1;
        e++;
        step;
        chk("tick_count", 8'(o_count), 8'(exp_cnt(e)));
      end
    end
    i_bauden = 1'b0;
    i_rx = 1'b1;
  endtask

  task automatic run_frame(input vec_t v);
    exp_t x;
    pulse_clear;
    sb.push_back('{v.data, v.perr_even, v.perr_odd});
    feed(v.data, v.pbit, 160, v.pause_at, v.pause_len);
    chk("start_err", 8'(o_start_err), 8'h00);
    if (v.together) begin
      i_load = 1'b1;
      i_pbit = 1'b1;
      step;
      i_load = 1'b0;
      i_pbit = 1'b0;
    end else begin
      i_load = 1'b1;
      step;
      i_load = 1'b0;
      i_pbit = 1'b1;
      step;
      i_pbit = 1'b0;
    end
    x = sb.pop_front();
    chk("data", o_data, x.data);
    chk("perr_even", 8'(o_parity_err), 8'(x.perr_even));
    chk("perr_odd", 8'(o_parity_err_o), 8'(x.perr_odd));
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hA3, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b1, -1, 0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h96, 1'b0, 60, 20, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1};
    step;
    step;
    chk("rst_count", 8'(o_count), 8'h00);
    chk("rst_data", o_data, 8'h00);
    chk("rst_perr", 8'(o_parity_err), 8'h00);
    chk("rst_start", 8'(o_start_err), 8'h00);
    rst = 1'b0;
    step;
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);
    pulse_clear;
    i_rx = 1'b0;
    repeat (3) step;
    i_rx = 1'b1;
    i_bauden = 1'b1;
    repeat (7) step;
    chk("glitch_pre", 8'(o_start_err), 8'h00);
    step;
    chk("glitch_start", 8'(o_start_err), 8'h01);
    chk("glitch_count", 8'(o_count), 8'h01);
    i_bauden = 1'b0;
    pulse_clear;
    feed(8'h3C, 1'b0, 140, -1, 0);
    chk("pre_clr_count", 8'(o_count), 8'h09);
    i_clear = 1'b1;
    i_load = 1'b1;
    step;
    i_clear = 1'b0;
    i_load = 1'b0;
    chk("clrload_data", o_data, 8'h3C);
    chk("clrload_count", 8'(o_count), 8'h00);
    chk("clrload_start", 8'(o_start_err), 8'h00);
    i_load = 1'b1;
    step;
    i_load = 1'b0;
    chk("clr_shreg", o_data, 8'h00);
    i_pbit = 1'b1;
    step;
    i_pbit = 1'b0;
    chk("clr_pbit_even", 8'(o_parity_err), 8'h00);
    chk("clr_pbit_odd", 8'(o_parity_err_o), 8'h01);
    run_frame('{8'hFF, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0});
    pulse_clear;
    i_bauden = 1'b1;
    repeat (72) step;
    chk("mid_count", 8'(o_count), 8'h05);
    chk("mid_start", 8'(o_start_err), 8'h01);
    rst = 1'b1;
    #1;
    chk("arst_count", 8'(o_count), 8'h00);
    chk("arst_data", o_data, 8'h00);
    chk("arst_perr", 8'(o_parity_err), 8'h00);
    chk("arst_start", 8'(o_start_err), 8'h00);
    i_bauden = 1'b0;
    step;
    rst = 1'b0;
    repeat (5) step;
    chk("idle_count", 8'(o_count), 8'h00);
    chk("idle_data", o_data, 8'h00);
    chk("idle_perr", 8'(o_parity_err_o), 8'h00);
    run_frame('{8'hFF, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_datapath.md
UART_RX_DATAPATH -- requirements
Module: uart_rx_datapath

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clock cycles per bit period; legal range 4..65535.
REQ-002 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 i_bauden  input  1  bit-timing enable from the receive controller.
REQ-007 i_clear  input  1  clear request from the receive controller.
REQ-008 i_load  input  1  one-cycle strobe that copies the shift register to o_data.
REQ-009 i_pbit  input  1  one-cycle strobe that evaluates parity on o_data.
REQ-010 o_count  output  count_t (4)  number of bits sampled in the current frame; returned to the controller.
REQ-011 o_data  output  8  last received byte.
REQ-012 o_parity_err  output  1  parity result of the last evaluated frame.
REQ-013 o_start_err  output  1  start bit sampled high in the current frame.

Function
REQ-014 i_rx shall pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 Baud counter (16 bit) runs while i_bauden=1 and i_clear=0; it wraps from BAUD_DIV-1 to 0; it holds when i_bauden=0.
REQ-016 Sample tick asserts for one cycle when the baud counter equals BAUD_DIV/2-1 (integer division) and i_bauden=1.
  - First tick: BAUD_DIV/2 cycles after i_bauden rises. Later ticks: every BAUD_DIV cycles (mid-bit).
REQ-017 Each tick increments o_count; o_count saturates at 10; ticks at count 10 have no effect.
REQ-018 Tick with o_count=0 (start bit): o_start_err <= synchronized rx.
REQ-019 Ticks with o_count=1..8: shift right, synchronized rx into bit 7; data is LSB-first.
REQ-020 Tick with o_count=9: the parity bit register captures synchronized rx.
REQ-021 i_clear=1: baud counter, o_count, shift register, parity bit register and o_start_err <= 0.
  - o_data and o_parity_err are held.
  - clear has priority over bauden and ticks in the same cycle.
REQ-022 i_load=1: o_data <= shift register on the next edge; this holds even when i_clear is asserted in the same cycle (it uses the pre-clear value).
REQ-023 i_pbit=1: o_parity_err <= (XOR of o_data) XOR parity bit register XOR PARITY_ODD.
REQ-024 i_load and i_pbit asserted together: parity uses the shift register value instead of o_data.
REQ-025 Latency: o_count updates 1 cycle after the tick; o_data 1 cycle after i_load; o_parity_err 1 cycle after i_pbit.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 On rst, asynchronously:
  - synchronizer flops <= 1;
  - baud counter, o_count, shift register, parity bit register <= 0;
  - o_data <= 8'h00; o_parity_err <= 0; o_start_err <= 0.
REQ-028 rst asserted mid-frame shall abandon the frame; after release, no output changes until the controller drives the strobes again.

Structure
REQ-029 pkg_uart holds:
  - count_t (4-bit logic);
  - LAST_COUNT = 4'd10;
  - default BAUD_DIV and PARITY_ODD constants.
REQ-030 Baud counter and tick generation shall be one sub-module, uart_baud_tick (inputs: clk, rst, enable, clear; output: tick).
REQ-031 Synchronizer, shift register, counters and output registers stay in uart_rx_datapath.

Verification (BAUD_DIV=16, even parity unless stated)
REQ-032 Frame 0x55, parity 0, stop 1; bauden held 160 cycles; load, then pbit:
  - ticks at cycles 8, 24, ..., 152; o_count reaches 10;
  - o_data=8'h55; o_parity_err=0; o_start_err=0.
REQ-033 Frame 0xA3 with wrong parity bit 1 -> o_data=8'hA3, o_parity_err=1; repeat with PARITY_ODD=1 -> o_parity_err=0.
REQ-034 Glitch: rx low for 3 cycles only, bauden then held -> o_start_err=1 after the first tick.
REQ-035 Clear and load in the same cycle with shift register 8'h3C -> o_data=8'h3C; o_count=0; shift register=0.
REQ-036 rst pulse at o_count=5 -> all outputs 0 within the same cycle, before the next clk edge; next frame 0xFF -> o_data=8'hFF.
REQ-037 bauden dropped for 20 cycles at o_count=4 -> no ticks and count held at 4; sampling resumes with the same phase.
